bound_flasher_monitor: RTL and testbench
========================================

BOUND_FLASHER_MONITOR -- requirements
Module: bound_flasher_monitor

Interface
REQ-001 The block SHALL have these ports, one per line (name, direction, width, meaning).
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-low.
- flick  input  1  same flick signal driven into the flasher.
- led  input  16  LED bus under observation; bit 0 = led0.
- level  output  5  number of lit LEDs, 0..16, registered.
- phase  output  3  0 = IDLE, 1..6 = flasher phase, 7 = ERR.
- peak_vld  output  1  one-cycle pulse on an up-to-down reversal.
- peak_level  output  5  level at the last reversal; held until the next one.
- kick  output  1  one-cycle pulse on an accepted kickback.
- cycle_done  output  1  one-cycle pulse when phase 6 reaches level 0.
- err  output  1  sticky error flag.
- err_code  output  2  00 none, 01 ENC, 10 STEP, 11 SEQ; holds the first error.

Function
REQ-002 The block SHALL sample led every clk and form the current level L = count of lit LEDs; P = registered previous level.
REQ-003 The block SHALL raise ENC when led is not thermometer code (led != 2^L-1).
REQ-004 The block SHALL raise STEP when |L-P| > 1 in one cycle.
REQ-005 L == P SHALL be a hold: no phase change, no error.
REQ-006 Phase transitions (rise = L=P+1, fall = L=P-1) SHALL be:
- IDLE: rise from 0 -> 1.
- 1: fall at P=6 -> 2.
- 2: rise at P=0 -> 3.
- 3: fall at P=11 -> 4; fall at P=6 -> 2 with kick.
- 4: rise at P=6 -> 5.
- 5: fall at P=16 -> 6; fall at P=11 -> 4 with kick.
- 6: reaching L=0 -> IDLE with cycle_done.
REQ-007 Any other reversal, any fall below 6 in phase 4, and any rise in phase 6 SHALL raise SEQ.
REQ-008 A kick reversal SHALL be legal only when flick was sampled high at least once since the previous reversal or phase entry; otherwise the block SHALL raise SEQ.
REQ-009 On every reversal from up to down, peak_vld SHALL pulse in the same cycle the phase update registers, and peak_level SHALL load P.
REQ-010 All outputs SHALL be registered, with 1-cycle latency from the led sample.
REQ-011 On the first error, phase SHALL go to 7, err SHALL set, and err_code SHALL latch; later errors SHALL not overwrite it.
REQ-012 In ERR, the block SHALL freeze the phase and suppress pulses; level SHALL continue tracking.
REQ-013 If ENC and STEP occur in the same cycle, ENC SHALL take priority; STEP SHALL take priority over SEQ.
REQ-014 flick asserted in IDLE with led == 0 SHALL not change the phase.

Reset
REQ-015 When rst = 0 at a clk edge, the block SHALL clear all outputs: level = 0, phase = 0, peak_level = 0, pulses = 0, err = 0, err_code = 00, P = 0, and the flick-seen flag.
REQ-016 Reset SHALL override any phase, including ERR and mid-cycle states; monitoring SHALL resume from IDLE on the next edge.

Configuration
REQ-017 With macro BOUND_FLASHER_MONITOR_STATS_EN defined, the block SHALL add two outputs:
- kick_cnt[7:0]: count of kick pulses, saturating at 255.
- cycle_cnt[7:0]: count of cycle_done pulses, saturating at 255.
Both SHALL clear on reset.
REQ-018 Without BOUND_FLASHER_MONITOR_STATS_EN, these ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Normal flow: flasher driven with one flick pulse -> peaks at 6, 11, 16 in order; cycle_done pulses once; err = 0.
- Kickback at led5 in phase 3: flick during the rise to level 6 -> kick = 1, peak_level = 6, phase returns to 2; the sequence then completes with err = 0.
- Kickback at led10 in phase 5: flick at level 11 -> kick = 1, phase = 4; cycle_done pulses later.
- Kick without flick: led forced to fall at level 6 in phase 3 with flick held 0 -> err_code = 11, phase = 7.
- Bad encoding / step: led = 16'h0005 -> err_code = 01; led jumping from 16'h0003 to 16'h000F -> err_code = 10.
- Reset mid-operation: rst pulsed low during phase 4 -> all outputs 0 on the next edge; a new flick completes a clean cycle.

Source files
------------

// File: rtl/bound_flasher_monitor.sv
// Bound-flasher monitor: checks an observed 16-LED bus against the flasher's phase sequence.
// Optional kick/cycle statistics outputs are enabled by defining BOUND_FLASHER_MONITOR_STATS_EN.
module bound_flasher_monitor (
  input  logic        clk,
  input  logic        rst,
  input  logic        flick,
  input  logic [15:0] led,
  output logic [4:0]  level,
  output logic [2:0]  phase,
  output logic        peak_vld,
  output logic [4:0]  peak_level,
  output logic        kick,
  output logic        cycle_done,
  output logic        err,
  output logic [1:0]  err_code
`ifdef BOUND_FLASHER_MONITOR_STATS_EN
  ,
  output logic [7:0]  kick_cnt,
  output logic [7:0]  cycle_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_P1 = 3'd1, S_P2 = 3'd2, S_P3 = 3'd3,
    S_P4   = 3'd4, S_P5 = 3'd5, S_P6 = 3'd6, S_ERR = 3'd7
  } state_t;

  state_t      state, nxt;
  logic [4:0]  cnt;
  logic [16:0] therm;
  logic [5:0]  l6, p6;
  logic        enc, step, rise, fall, seq, seen, seen_eff, seen_nxt;
  logic        pk, kk, cd, err_now;
  logic [1:0]  code;

  // level register doubles as the previous-sample level P
  always_comb begin
    cnt = '0;
    for (int i = 0; i < 16; i++) cnt = cnt + 5'(led[i]);
    therm    = (17'd1 << cnt) - 17'd1;
    l6       = {1'b0, cnt};
    p6       = {1'b0, level};
    enc      = ({1'b0, led} != therm);
    step     = (l6 > p6 + 6'd1) || (p6 > l6 + 6'd1);
    rise     = (l6 == p6 + 6'd1);
    fall     = (p6 == l6 + 6'd1);
    seen_eff = seen | flick;
  end

  always_comb begin
    nxt = state;
    seq = 1'b0;
    pk  = 1'b0;
    kk  = 1'b0;
    cd  = 1'b0;
    unique case (state)
      S_IDLE: if (rise) nxt = S_P1;
      S_P1: if (fall) begin
        if (level == 5'd6) begin nxt = S_P2; pk = 1'b1; end
        else seq = 1'b1;
      end
      S_P2: if (rise) begin
        if (level == 5'd0) nxt = S_P3;
        else seq = 1'b1;
      end
      S_P3: if (fall) begin
        if (level == 5'd11) begin nxt = S_P4; pk = 1'b1; end
        else if (level == 5'd6 && seen_eff) begin nxt = S_P2; pk = 1'b1; kk = 1'b1; end
        else seq = 1'b1;
      end
      S_P4: begin
        if (rise) begin
          if (level == 5'd6) nxt = S_P5;
          else seq = 1'b1;
        end else if (fall && cnt < 5'd6) seq = 1'b1;
      end
      S_P5: if (fall) begin
        if (level == 5'd16) begin nxt = S_P6; pk = 1'b1; end
        else if (level == 5'd11 && seen_eff) begin nxt = S_P4; pk = 1'b1; kk = 1'b1; end
        else seq = 1'b1;
      end
      S_P6: begin
        if (rise) seq = 1'b1;
        else if (fall && cnt == 5'd0) begin nxt = S_IDLE; cd = 1'b1; end
      end
      S_ERR: ;
      default: ;
    endcase
    code    = enc ? 2'b01 : (step ? 2'b10 : 2'b11);
    err_now = (state != S_ERR) && (enc || step || seq);
    // an error cycle produces no pulses and freezes in ERR
    if (err_now) begin
      nxt = S_ERR;
      pk  = 1'b0;
      kk  = 1'b0;
      cd  = 1'b0;
    end
    seen_nxt = (nxt != state) ? 1'b0 : seen_eff;
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= nxt;
  end

  assign phase = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      level      <= '0;
      peak_vld   <= 1'b0;
      peak_level <= '0;
      kick       <= 1'b0;
      cycle_done <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'b00;
      seen       <= 1'b0;
    end else begin
      level      <= cnt;
      peak_vld   <= pk;
      kick       <= kk;
      cycle_done <= cd;
      seen       <= seen_nxt;
      if (pk) peak_level <= level;
      if (err_now) begin
        err      <= 1'b1;
        err_code <= code;
      end
    end
  end

`ifdef BOUND_FLASHER_MONITOR_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      kick_cnt  <= '0;
      cycle_cnt <= '0;
    end else begin
      if (kk && kick_cnt != 8'hFF)  kick_cnt  <= kick_cnt + 8'd1;
      if (cd && cycle_cnt != 8'hFF) cycle_cnt <= cycle_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bound_flasher_monitor.sv
// Directed bench for bound_flasher_monitor: table-driven phase model checked every cycle,
// plus literal expectations for each flasher scenario.
module tb_bound_flasher_monitor;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flick = 1'b0;
  logic [15:0] led = '0;
  logic [4:0]  level, peak_level;
  logic [2:0]  phase;
  logic        peak_vld, kick, cycle_done, err;
  logic [1:0]  err_code;
`ifdef BOUND_FLASHER_MONITOR_STATS_EN
  logic [7:0]  kick_cnt, cycle_cnt;
`endif

  bound_flasher_monitor dut (
    .clk(clk), .rst(rst), .flick(flick), .led(led),
    .level(level), .phase(phase), .peak_vld(peak_vld), .peak_level(peak_level),
    .kick(kick), .cycle_done(cycle_done), .err(err), .err_code(err_code)
`ifdef BOUND_FLASHER_MONITOR_STATS_EN
    , .kick_cnt(kick_cnt), .cycle_cnt(cycle_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit run = 1'b0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] b);
    checks++;
    if (a !== b) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, b, $time);
    end
  endtask

  // Legal exits of each phase: (phase, rising, P, next, kick, peak, cycle_done)
  typedef struct { int ph; bit up; int p; int nx; bit kk; bit pk; bit cd; } exit_t;
  exit_t ex[9];
  bit norm_up[7] = '{1, 1, 0, 1, 0, 1, 0};
  int floor_l[7] = '{0, 0, 0, 0, 6, 0, 0};

  initial begin
    ex[0] = '{0, 1, 0,  1, 0, 0, 0};
    ex[1] = '{1, 0, 6,  2, 0, 1, 0};
    ex[2] = '{2, 1, 0,  3, 0, 0, 0};
    ex[3] = '{3, 0, 11, 4, 0, 1, 0};
    ex[4] = '{3, 0, 6,  2, 1, 1, 0};
    ex[5] = '{4, 1, 6,  5, 0, 0, 0};
    ex[6] = '{5, 0, 16, 6, 0, 1, 0};
    ex[7] = '{5, 0, 11, 4, 1, 1, 0};
    ex[8] = '{6, 0, 1,  0, 0, 0, 1};
  end

  int m_phase, m_level, m_pkl, m_code, m_kc, m_cc;
  bit m_pk, m_kick, m_cd, m_err, m_seen;
  int lv, np, code, hit;
  bit up;

  always @(posedge clk) begin
    if (!rst) begin
      m_phase = 0; m_level = 0; m_pkl = 0; m_code = 0; m_kc = 0; m_cc = 0;
      m_pk = 0; m_kick = 0; m_cd = 0; m_err = 0; m_seen = 0;
    end else begin
      m_pk = 0; m_kick = 0; m_cd = 0;
      lv = $countones(led);
      if (m_phase != 7) begin
        np = m_phase;
        code = 0;
        if (led != 16'((32'd1 << lv) - 1)) code = 1;
        else if (lv > m_level + 1 || m_level > lv + 1) code = 2;
        else if (lv != m_level) begin
          up = (lv > m_level);
          hit = -1;
          for (int i = 0; i < 9; i++)
            if (ex[i].ph == m_phase && ex[i].up == up && ex[i].p == m_level) hit = i;
          if (hit >= 0) begin
            if (ex[hit].kk && !(m_seen || flick)) code = 3;
            else begin
              np = ex[hit].nx;
              m_kick = ex[hit].kk; m_pk = ex[hit].pk; m_cd = ex[hit].cd;
              if (m_pk) m_pkl = m_level;
              if (m_kick && m_kc < 255) m_kc++;
              if (m_cd && m_cc < 255) m_cc++;
            end
          end else if (up != norm_up[m_phase] || lv < floor_l[m_phase]) code = 3;
        end
        if (code != 0) begin np = 7; m_err = 1; m_code = code; end
        m_seen = (np != m_phase) ? 1'b0 : (m_seen | flick);
        m_phase = np;
      end
      m_level = lv;
    end
  end

  // Every-cycle comparison against the model, plus pulse tallies for scenario checks
  int peaks[$];
  int cdn = 0, kn = 0;
  always @(negedge clk) begin
    if (run) begin
      chk("level", level, m_level);
      chk("phase", phase, m_phase);
      chk("peak_vld", peak_vld, m_pk);
      chk("peak_level", peak_level, m_pkl);
      chk("kick", kick, m_kick);
      chk("cycle_done", cycle_done, m_cd);
      chk("err", err, m_err);
      chk("err_code", err_code, m_code);
`ifdef BOUND_FLASHER_MONITOR_STATS_EN
      chk("kick_cnt", kick_cnt, m_kc);
      chk("cycle_cnt", cycle_cnt, m_cc);
`endif
      if (peak_vld) peaks.push_back(int'(peak_level));
      if (cycle_done) cdn++;
      if (kick) kn++;
    end
  end

  task automatic raw(input logic [15:0] v, input bit f);
    @(negedge clk);
    led = v;
    flick = f;
  endtask

  task automatic stp(input int l, input bit f);
    raw(16'((32'd1 << l) - 1), f);
  endtask

  task automatic ramp(input int a, input int b, input bit f);
    if (a <= b) for (int i = a; i <= b; i++) stp(i, f);
    else        for (int i = a; i >= b; i--) stp(i, f);
  endtask

  task automatic settle;
    @(posedge clk);
    #1;
  endtask

  task automatic zeros(input string n);
    chk({n, "_level"}, level, 0);
    chk({n, "_phase"}, phase, 0);
    chk({n, "_peak_level"}, peak_level, 0);
    chk({n, "_pulses"}, {peak_vld, kick, cycle_done}, 0);
    chk({n, "_err"}, err, 0);
    chk({n, "_err_code"}, err_code, 0);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b0; led = '0; flick = 1'b0;
    settle;
    zeros("rst");
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic rest_of_cycle;
    ramp(1, 11, 0); ramp(10, 6, 0); ramp(7, 16, 0); ramp(15, 0, 0);
    stp(0, 0); stp(0, 0);
  endtask

  int c0;

  initial begin
    // reset state
    settle;
    zeros("init");
    run = 1'b1;
    @(negedge clk);
    rst = 1'b1;

    // flick in IDLE with dark bus keeps IDLE, then one full flasher cycle
    stp(0, 1); stp(0, 0);
    settle;
    chk("idle_flick_phase", phase, 0);
    peaks.delete(); c0 = cdn;
    ramp(1, 6, 0); ramp(5, 0, 0); rest_of_cycle();
    settle;
    chk("norm_npeaks", peaks.size(), 3);
    if (peaks.size() == 3) begin
      chk("norm_peak0", peaks[0], 6);
      chk("norm_peak1", peaks[1], 11);
      chk("norm_peak2", peaks[2], 16);
    end
    chk("norm_cd", cdn - c0, 1);
    chk("norm_err", err, 0);
    chk("norm_phase", phase, 0);

    // kickback at led5 in phase 3
    c0 = cdn;
    ramp(1, 6, 0); ramp(5, 0, 0); ramp(1, 2, 0); stp(3, 1); ramp(4, 6, 0); stp(5, 0);
    settle;
    chk("k3_kick", kick, 1);
    chk("k3_peak", peak_level, 6);
    chk("k3_phase", phase, 2);
    ramp(4, 0, 0); rest_of_cycle();
    settle;
    chk("k3_err", err, 0);
    chk("k3_cd", cdn - c0, 1);

    // kickback at led10 in phase 5
    c0 = cdn;
    ramp(1, 6, 0); ramp(5, 0, 0); ramp(1, 11, 0); ramp(10, 7, 0); ramp(6, 10, 0);
    stp(11, 1); stp(10, 0);
    settle;
    chk("k5_kick", kick, 1);
    chk("k5_phase", phase, 4);
    chk("k5_peak", peak_level, 11);
    ramp(9, 6, 0); ramp(7, 16, 0); ramp(15, 0, 0); stp(0, 0);
    settle;
    chk("k5_cd", cdn - c0, 1);
    chk("k5_err", err, 0);
    chk("kick_total", kn, 2);

    // kick without flick
    ramp(1, 6, 0); ramp(5, 0, 0); ramp(1, 6, 0); stp(5, 0);
    settle;
    chk("nok_code", err_code, 3);
    chk("nok_phase", phase, 7);
    chk("nok_kick", kick, 0);
    stp(4, 0);
    settle;
    chk("nok_track", level, 4);

    // bad encoding (also a step from 0): encoding wins
    do_reset();
    raw(16'h0005, 0);
    settle;
    chk("enc_code", err_code, 1);
    chk("enc_phase", phase, 7);
    raw(16'h0007, 0);
    settle;
    chk("enc_track", level, 3);

    // step error, then later errors do not overwrite
    do_reset();
    raw(16'h0001, 0); raw(16'h0003, 0); raw(16'h000F, 0);
    settle;
    chk("step_code", err_code, 2);
    raw(16'h0005, 0);
    settle;
    chk("step_hold", err_code, 2);
    chk("step_err", err, 1);

    // reset mid phase 4, then a clean cycle
    do_reset();
    ramp(1, 6, 0); ramp(5, 0, 0); ramp(1, 11, 0); ramp(10, 8, 0);
    settle;
    chk("mid_phase4", phase, 4);
    @(negedge clk);
    rst = 1'b0;
    settle;
    zeros("mid");
    @(negedge clk);
    rst = 1'b1; led = '0;
    c0 = cdn;
    stp(0, 1);
    ramp(1, 6, 0); ramp(5, 0, 0); rest_of_cycle();
    settle;
    chk("mid_cd", cdn - c0, 1);
    chk("mid_err", err, 0);

    @(negedge clk);
    run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
